// File: rtl/mem_loader_pkg.sv
// Shared types and defaults for the program-memory loader.
// Holds the FSM state encoding, the default geometry and the depth helper.
package mem_loader_pkg;

  localparam int DEF_ADDR_W        = 6;
  localparam int DEF_DATA_W        = 8;
  localparam int DEF_RELEASE_DELAY = 2;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_HOLD  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  function automatic int depth(input int addr_w);
    return int'(32'd1 << addr_w);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Program memory: one synchronous write port, one asynchronous read port.
// Contents survive reset so a partial image stays until it is overwritten.
module mem_array
  import mem_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = depth(ADDR_W);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage write; deliberately no reset on the array
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/mem_loader.sv
// Streams a program image into memory while holding the CPU in reset,
// zero-fills the unloaded tail, waits a settle interval, then serves the CPU.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int RELEASE_DELAY = DEF_RELEASE_DELAY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] adr_bus,
  input  logic              rd_mem,
  input  logic              wr_mem,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   FULL_COUNT = COUNT_ONE << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};
  localparam logic [3:0]        HOLD_LAST  = 4'(RELEASE_DELAY - 1);

  state_t            state_r, state_s;
  logic [ADDR_W:0]   load_count_r, load_count_s;
  logic [ADDR_W-1:0] fill_ptr_r, fill_ptr_s;
  logic [3:0]        hold_cnt_r, hold_cnt_s;
  logic              ld_ready_r, load_done_r, cpu_reset_r;
  logic              accept_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic [DATA_W-1:0] mem_rdata_s;

  // Next-state, counters and the state-owned memory write port
  always_comb begin
    state_s      = state_r;
    load_count_s = load_count_r;
    fill_ptr_s   = fill_ptr_r;
    hold_cnt_s   = hold_cnt_r;
    accept_s     = 1'b0;
    mem_we_s     = 1'b0;
    mem_waddr_s  = load_count_r[ADDR_W-1:0];
    mem_wdata_s  = ld_data;
    case (state_r)
      ST_LOAD: begin
        accept_s    = ld_valid && ld_ready_r;
        mem_we_s    = accept_s;
        mem_waddr_s = load_count_r[ADDR_W-1:0];
        mem_wdata_s = ld_data;
        if (accept_s) begin
          load_count_s = load_count_r + COUNT_ONE;
          // A full image skips the tail fill entirely
          if (load_count_s == FULL_COUNT) begin
            state_s    = ST_HOLD;
            hold_cnt_s = 4'd0;
          end else if (ld_last) begin
            state_s    = ST_CLEAR;
            fill_ptr_s = load_count_s[ADDR_W-1:0];
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = fill_ptr_r;
        mem_wdata_s = {DATA_W{1'b0}};
        if (fill_ptr_r == LAST_ADDR) begin
          state_s    = ST_HOLD;
          hold_cnt_s = 4'd0;
        end else begin
          fill_ptr_s = fill_ptr_r + ADDR_ONE;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_r == HOLD_LAST) begin
          state_s = ST_RUN;
        end else begin
          hold_cnt_s = hold_cnt_r + 4'd1;
        end
      end
      ST_RUN: begin
        mem_we_s    = wr_mem;
        mem_waddr_s = adr_bus;
        mem_wdata_s = cpu_wdata;
      end
      default: begin
        state_s = ST_LOAD;
      end
    endcase
  end

  // State and registered status outputs, all derived from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_LOAD;
      load_count_r <= {(ADDR_W+1){1'b0}};
      fill_ptr_r   <= {ADDR_W{1'b0}};
      hold_cnt_r   <= 4'd0;
      ld_ready_r   <= 1'b0;
      load_done_r  <= 1'b0;
      cpu_reset_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      load_count_r <= load_count_s;
      fill_ptr_r   <= fill_ptr_s;
      hold_cnt_r   <= hold_cnt_s;
      ld_ready_r   <= (state_s == ST_LOAD);
      load_done_r  <= (state_s == ST_HOLD) || (state_s == ST_RUN);
      cpu_reset_r  <= (state_s == ST_RUN);
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (mem_waddr_s),
    .wdata (mem_wdata_s),
    .raddr (adr_bus),
    .rdata (mem_rdata_s)
  );

  // Read data is pre-write contents when a CPU write hits the same address
  assign cpu_rdata  = ((state_r == ST_RUN) && rd_mem) ? mem_rdata_s : {DATA_W{1'b0}};
  assign ld_ready   = ld_ready_r;
  assign load_done  = load_done_r;
  assign cpu_reset  = cpu_reset_r;
  assign load_count = load_count_r;

endmodule

// File: tb/tb_mem_loader.sv
// Directed/randomized bench for mem_loader with a behavioural memory model:
// expected memory = accepted image bytes, zeros in the unloaded tail, CPU writes in RUN.
module tb_mem_loader;

  logic       clk;
  logic       reset;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic [5:0] adr_bus;
  logic       rd_mem;
  logic       wr_mem;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_reset;
  logic       load_done;
  logic [6:0] load_count;

  logic [7:0] img   [64];
  logic [7:0] model [64];
  int n_tests = 0;
  int n_fail  = 0;

  mem_loader #(.ADDR_W(6), .DATA_W(8), .RELEASE_DELAY(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .adr_bus    (adr_bus),
    .rd_mem     (rd_mem),
    .wr_mem     (wr_mem),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_count (load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; asserts reset mid-cycle, checks async effect, releases it
  task automatic do_reset();
    adr_bus = 6'd0;
    rd_mem  = 1'b1;
    wr_mem  = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_count", load_count, 0);
    check("rst_cpu_reset", cpu_reset, 0);
    check("rst_load_done", load_done, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_rdata", cpu_rdata, 0);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    @(negedge clk);
    reset  = 1'b1;
    rd_mem = 1'b0;
    @(negedge clk);
    check("ready_after_rst", ld_ready, 1);
    check("count_after_rst", load_count, 0);
  endtask

  // Streams img[0..k-1]; optional random gaps; CPU strobes held active throughout
  task automatic load_image(input int k, input bit gaps);
    int acc = 0;
    int guard = 0;
    bit v;
    while (acc < k && guard < 1000) begin
      check("load_count", load_count, acc);
      check("load_ready", ld_ready, 1);
      check("load_rdata", cpu_rdata, 0);
      v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      ld_valid  = v;
      ld_data   = img[acc];
      ld_last   = (acc == k - 1);
      wr_mem    = 1'b1;
      rd_mem    = 1'b1;
      adr_bus   = 6'd0;
      cpu_wdata = 8'hFF;
      if (v) begin
        model[acc] = img[acc];
        acc++;
      end
      guard++;
      @(negedge clk);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // From the negedge after the final beat until the CPU is released
  task automatic wait_run(input int k);
    int clr = 0;
    int hld = 0;
    int cyc = 0;
    ld_valid  = 1'b1;
    ld_last   = 1'b0;
    ld_data   = 8'hEE;
    wr_mem    = 1'b1;
    rd_mem    = 1'b1;
    adr_bus   = 6'd0;
    cpu_wdata = 8'hFF;
    while (cpu_reset !== 1'b1 && cyc < 300) begin
      check("pre_rdata", cpu_rdata, 0);
      check("pre_ready", ld_ready, 0);
      check("pre_count", load_count, k);
      if (load_done === 1'b1) hld++;
      else clr++;
      cyc++;
      @(negedge clk);
    end
    ld_valid = 1'b0;
    wr_mem   = 1'b0;
    rd_mem   = 1'b0;
    check("run_reached", cpu_reset, 1);
    check("clear_cycles", clr, 64 - k);
    check("hold_cycles", hld, 2);
    check("done_in_run", load_done, 1);
    check("count_in_run", load_count, k);
    for (int i = k; i < 64; i++) model[i] = 8'h00;
  endtask

  task automatic read_all();
    for (int a = 0; a < 64; a++) begin
      adr_bus = 6'(a);
      rd_mem  = 1'b1;
      #1;
      check($sformatf("read[%0d]", a), cpu_rdata, model[a]);
      @(negedge clk);
    end
    rd_mem = 1'b0;
    #1;
    check("no_rd_zero", cpu_rdata, 0);
  endtask

  initial begin
    int k;
    reset     = 1'b1;
    ld_valid  = 1'b0;
    ld_data   = 8'h00;
    ld_last   = 1'b0;
    adr_bus   = 6'd0;
    rd_mem    = 1'b0;
    wr_mem    = 1'b0;
    cpu_wdata = 8'h00;
    for (int i = 0; i < 64; i++) model[i] = 8'h00;
    @(negedge clk);
    do_reset();

    // Full load, no gaps
    for (int i = 0; i < 64; i++) img[i] = 8'(i) ^ 8'hA5;
    load_image(64, 1'b0);
    wait_run(64);
    read_all();

    // CPU write, read-back, and read-during-write
    @(negedge clk);
    adr_bus   = 6'h2A;
    wr_mem    = 1'b1;
    cpu_wdata = 8'h5C;
    rd_mem    = 1'b0;
    @(negedge clk);
    wr_mem = 1'b0;
    rd_mem = 1'b1;
    #1 check("cpu_wr_rd", cpu_rdata, 8'h5C);
    wr_mem    = 1'b1;
    cpu_wdata = 8'h01;
    #1 check("rd_during_wr", cpu_rdata, 8'h5C);
    @(negedge clk);
    wr_mem = 1'b0;
    #1 check("rd_after_wr", cpu_rdata, 8'h01);
    model[6'h2A] = 8'h01;
    read_all();

    // Short load with tail fill
    do_reset();
    img[0] = 8'h11;
    img[1] = 8'h22;
    img[2] = 8'h33;
    load_image(3, 1'b0);
    wait_run(3);
    read_all();

    // Random gaps, random length and data
    do_reset();
    k = int'($urandom_range(4, 60));
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom_range(0, 255));
    load_image(k, 1'b1);
    wait_run(k);
    read_all();

    // Reset after 10 bytes, then full reload
    do_reset();
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 10; i++) begin
      ld_valid = 1'b1;
      ld_data  = img[i];
      ld_last  = 1'b0;
      @(negedge clk);
    end
    ld_valid = 1'b0;
    check("partial_count", load_count, 10);
    do_reset();
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom_range(0, 255));
    load_image(64, 1'b0);
    wait_run(64);
    read_all();

    // Reset during RUN, then full reload
    do_reset();
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom_range(0, 255));
    load_image(64, 1'b0);
    wait_run(64);
    read_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Program-memory subsystem on the CPU's memory side. Owns the 64×8 memory the CPU addresses over its 6-bit address bus, and holds the CPU in reset while a program image is streamed in over a byte-wide valid/ready port. It zero-fills any unloaded tail, waits a short settle interval, then releases the CPU and serves its `rd_mem`/`wr_mem` accesses.

## Interface

Parameters:
- `ADDR_W`, default 6: address width; memory depth is `DEPTH = 2**ADDR_W`.
- `DATA_W`, default 8: data width.
- `RELEASE_DELAY`, default 2: cycles spent in HOLD before the CPU is released; legal range 1..15.

Ports:
- `clk` input, 1: single clock, rising edge.
- `reset` input, 1: asynchronous, active-low.
- `ld_valid` input, 1: load byte valid.
- `ld_data` input, `DATA_W`: load byte.
- `ld_last` input, 1: marks the final byte of the image; qualified by `ld_valid && ld_ready`.
- `ld_ready` output, 1: loader accepts a byte.
- `adr_bus` input, `ADDR_W`: CPU address.
- `rd_mem` input, 1: CPU read strobe.
- `wr_mem` input, 1: CPU write strobe.
- `cpu_wdata` input, `DATA_W`: CPU write data (the CPU's data-out bus).
- `cpu_rdata` output, `DATA_W`: CPU read data (the CPU's data-in bus).
- `cpu_reset` output, 1: active-low reset driven into the CPU.
- `load_done` output, 1: high once the image is loaded and the tail is filled.
- `load_count` output, `ADDR_W+1`: number of bytes accepted, 0..`DEPTH`.

## Operation

**States:** LOAD → CLEAR → HOLD → RUN. RUN is terminal until `reset`.

**Reset (`reset`=0):**
- State goes to LOAD; `load_count`=0, `cpu_reset`=0, `load_done`=0, `ld_ready`=0, `cpu_rdata`=0.
- Memory contents are not reset.

**LOAD:**
- `ld_ready`=1.
- Each accepted beat writes `mem[load_count] = ld_data` and increments `load_count`.
- Beat with `ld_last`=1 and new count < `DEPTH`: go to CLEAR, with the fill pointer set to the new count.
- Beat that makes the count `DEPTH`, whether or not `ld_last` is set: go directly to HOLD.

**CLEAR:**
- `ld_ready`=0.
- Writes 0 to one address per cycle, from the fill pointer up to `DEPTH-1`.
- After writing `DEPTH-1`, go to HOLD. The pointer does not wrap.

**HOLD:**
- `load_done`=1.
- A counter runs for `RELEASE_DELAY` cycles, then the block goes to RUN.

**RUN:**
- `cpu_reset`=1.
- `cpu_rdata = rd_mem ? mem[adr_bus] : 0`. This is a combinational (asynchronous) read.
- `wr_mem`=1 writes `cpu_wdata` to `mem[adr_bus]` at the clock edge.
- `rd_mem` and `wr_mem` both high: the write occurs, and `cpu_rdata` shows the pre-write contents in that cycle.

**Outside RUN:**
- CPU strobes are ignored and `cpu_rdata`=0.
- `ld_valid` is ignored outside LOAD; no beat is consumed.

**Reset mid-operation:** the FSM returns to LOAD immediately and `cpu_reset` falls asynchronously. Memory keeps its partial contents until they are overwritten by the next load.

**Memory write-port arbitration** is fixed by state: loader in LOAD, filler in CLEAR, CPU in RUN.

## Timing

- Beat accepted at edge N: the byte is in memory and `load_count` is updated after edge N.
- `ld_ready` is a pure function of state. There is no combinational path from `ld_valid` to `ld_ready`.
- A short load of k bytes (k < `DEPTH`) spends `DEPTH-k` cycles in CLEAR.
- `load_done` rises in the first HOLD cycle.
- `cpu_reset` is registered. It rises in the first RUN cycle, `RELEASE_DELAY` cycles after HOLD is entered.
- `cpu_rdata` has zero-cycle latency from `adr_bus`/`rd_mem`.
- A CPU write at edge N is visible to a read in cycle N+1.
- `reset` assertion is asynchronous. Deassertion is synchronised externally, and `ld_ready` rises on the first clock after deassertion.

## Structure

**Shared package `mem_loader_pkg`:**
- State enum (LOAD, CLEAR, HOLD, RUN).
- Default `ADDR_W`, `DATA_W`, `RELEASE_DELAY`.
- The `DEPTH` function.

**Sub-module `mem_array`:**
- `DEPTH`×`DATA_W` register array.
- One synchronous write port (`we`, `waddr`, `wdata`) and one asynchronous read port.
- No reset.

**Top level:** FSM, counters, write-port mux and read gating.

## Test plan

1. **Full load.** Stream 64 bytes (value = address XOR 0xA5) with no gaps.
   - `load_count`=64.
   - No CLEAR cycles; `load_done` at the following edge.
   - `cpu_reset` rises 2 cycles later.
   - RUN reads of all 64 addresses match.
2. **Short load.** 3 bytes (0x11, 0x22, 0x33), with `ld_last` on the third.
   - 61 CLEAR cycles, then `load_done`.
   - Reads: addresses 0..2 return the loaded bytes; addresses 3..63 return 0x00.
3. **Backpressure and gaps.** `ld_valid` toggles randomly during LOAD.
   - Only handshaked beats count.
   - `ld_valid` held high during CLEAR/HOLD consumes nothing.
   - `load_count` stays at the accepted total.
4. **CPU access in RUN.**
   - Write 0x5C to address 0x2A, then read it next cycle: returns 0x5C.
   - Simultaneous `rd_mem`/`wr_mem` to address 0x2A with `cpu_wdata`=0x01: the same-cycle read returns 0x5C, and the next read returns 0x01.
5. **CPU strobes before RUN.**
   - `wr_mem`=1 with address 0x00 and data 0xFF during LOAD/HOLD: memory is unchanged.
   - `rd_mem` returns 0 until RUN.
6. **Reset mid-operation.**
   - Assert `reset` after 10 bytes: `cpu_reset` and `load_done` go to 0 and `load_count` goes to 0 asynchronously.
   - Reload 64 bytes: all new values read back correctly.
   - Repeat with `reset` asserted during RUN.
